// File: rtl/visitor_pkg.sv
// Shared types for the visitor direction detector: FSM states and sensor codes.
package visitor_pkg;

    // Crossing-tracking FSM states
    typedef enum logic [2:0] {
        IDLE,
        ENT1,
        ENT2,
        ENT3,
        EXT1,
        EXT2,
        EXT3,
        WAIT_CLR
    } state_t;

    // Sensor code {a_f, b_f}
    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] A    = 2'b10;
    localparam logic [1:0] B    = 2'b01;
    localparam logic [1:0] AB   = 2'b11;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stable-sample debounce filter for one
// raw beam-break sensor. The filtered level follows the synchronised input
// only after DEBOUNCE_CYCLES consecutive differing samples.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level_out
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    // The count reaches DEBOUNCE_CYCLES on the same edge that loads the level,
    // so the stored value never needs to exceed DEBOUNCE_CYCLES-1.
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic [CntW-1:0] cnt_q;

    // Synchronise the raw input and filter it against the current level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_out = level_q;

endmodule

// File: rtl/visitor_direction_detector.sv
// Debounces the outside (A) and inside (B) beam sensors and tracks the order
// in which they are broken, emitting one pulse per completed entry or exit.
module visitor_direction_detector
    import visitor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic entry_pulse,
    output logic exit_pulse,
    output logic timeout_pulse,
    output logic busy
);

    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);

    logic            a_f;
    logic            b_f;
    logic [1:0]      s;
    state_t          state_q;
    state_t          tbl_d;
    state_t          state_d;
    logic [TmrW-1:0] timer_q;
    logic [TmrW-1:0] timer_d;
    logic            in_crossing;
    logic            timeout_hit;
    logic            entry_done;
    logic            exit_done;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_a (
        .clk      (clk),
        .reset    (reset),
        .raw_in   (sensor_a),
        .level_out(a_f)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_b (
        .clk      (clk),
        .reset    (reset),
        .raw_in   (sensor_b),
        .level_out(b_f)
    );

    assign s = {a_f, b_f};

    // Transition table on the filtered sensor code; unlisted codes hold state
    always_comb begin
        tbl_d = state_q;
        unique case (state_q)
            IDLE: begin
                case (s)
                    A:       tbl_d = ENT1;
                    B:       tbl_d = EXT1;
                    AB:      tbl_d = WAIT_CLR;  // simultaneous onset is ambiguous
                    default: tbl_d = state_q;
                endcase
            end
            ENT1: begin
                case (s)
                    AB:      tbl_d = ENT2;
                    NONE:    tbl_d = IDLE;
                    B:       tbl_d = WAIT_CLR;
                    default: tbl_d = state_q;
                endcase
            end
            ENT2: begin
                case (s)
                    B:       tbl_d = ENT3;
                    A:       tbl_d = ENT1;
                    NONE:    tbl_d = IDLE;
                    default: tbl_d = state_q;
                endcase
            end
            ENT3: begin
                case (s)
                    NONE:    tbl_d = IDLE;
                    AB:      tbl_d = ENT2;
                    A:       tbl_d = WAIT_CLR;
                    default: tbl_d = state_q;
                endcase
            end
            EXT1: begin
                case (s)
                    AB:      tbl_d = EXT2;
                    NONE:    tbl_d = IDLE;
                    A:       tbl_d = WAIT_CLR;
                    default: tbl_d = state_q;
                endcase
            end
            EXT2: begin
                case (s)
                    A:       tbl_d = EXT3;
                    B:       tbl_d = EXT1;
                    NONE:    tbl_d = IDLE;
                    default: tbl_d = state_q;
                endcase
            end
            EXT3: begin
                case (s)
                    NONE:    tbl_d = IDLE;
                    AB:      tbl_d = EXT2;
                    B:       tbl_d = WAIT_CLR;
                    default: tbl_d = state_q;
                endcase
            end
            WAIT_CLR: begin
                tbl_d = (s == NONE) ? IDLE : WAIT_CLR;
            end
            default: tbl_d = IDLE;
        endcase
    end

    // Timeout only fires when the table would otherwise hold the state
    always_comb begin
        in_crossing = (state_q inside {ENT1, ENT2, ENT3, EXT1, EXT2, EXT3});
        timeout_hit = in_crossing && (tbl_d == state_q) && (timer_q == TmrLast);
        state_d     = timeout_hit ? WAIT_CLR : tbl_d;
        entry_done  = (state_q == ENT3) && (s == NONE);
        exit_done   = (state_q == EXT3) && (s == NONE);
        if (!in_crossing || (state_d != state_q)) begin
            timer_d = '0;
        end else if (timer_q == TmrLast) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // State, timer and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            entry_pulse   <= 1'b0;
            exit_pulse    <= 1'b0;
            timeout_pulse <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            entry_pulse   <= entry_done;
            exit_pulse    <= exit_done;
            timeout_pulse <= timeout_hit;
            busy          <= (state_d != IDLE);
        end
    end

endmodule

// File: doc/visitor_direction_detector.md
Name: visitor_direction_detector

Overview:
Upstream stage of the bidirectional visitor counter. It takes two raw beam-break sensors mounted across the doorway: A on the outside, B on the inside. It synchronises and debounces both sensors, then tracks the crossing order with an FSM. For each completed crossing it emits a one-cycle entry_pulse (A→AB→B→clear) or exit_pulse (B→AB→A→clear). These pulses drive the occupancy counter's increment and decrement inputs.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed before the filtered level changes (≥2)
TIMEOUT_CYCLES, 1000, cycles without an FSM state change before a partial crossing is abandoned (≥2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
sensor_a  in  1  raw outside sensor, 1 = beam broken, asynchronous to clk
sensor_b  in  1  raw inside sensor, 1 = beam broken, asynchronous to clk
entry_pulse  out  1  one-cycle pulse per completed entry
exit_pulse  out  1  one-cycle pulse per completed exit
timeout_pulse  out  1  one-cycle pulse when a partial crossing times out
busy  out  1  1 whenever the FSM is not in IDLE

Behaviour:
- Reset (synchronous, active-high): synchroniser flops, filtered levels, debounce counters, timer and all outputs go to 0; FSM goes to IDLE. Reset wins over all other activity, including mid-crossing; no pulse is emitted for an interrupted crossing.
- Input path, per sensor: 2-flop synchroniser, then debounce.
  - A stable-sample counter clears whenever the synchronised value equals the filtered level.
  - When the values differ, the counter increments. On reaching DEBOUNCE_CYCLES it loads the filtered level and clears.
  - Any glitch back to the filtered level restarts the count.
  - Latency from a clean raw edge to the filtered edge = 2 + DEBOUNCE_CYCLES cycles.
- Sensor code s = {a_f, b_f}: NONE=00, A=10, B=01, AB=11.
- FSM transitions are evaluated every cycle on s. Any code not listed for a state leaves the state unchanged.
  - IDLE: A→ENT1; B→EXT1; AB→WAIT_CLR (simultaneous onset is ambiguous and is never counted).
  - ENT1: AB→ENT2; NONE→IDLE (visitor backed out, no pulse); B→WAIT_CLR.
  - ENT2: B→ENT3; A→ENT1 (backtrack); NONE→IDLE (no pulse).
  - ENT3: NONE→IDLE and entry_pulse; AB→ENT2 (backtrack); A→WAIT_CLR.
  - EXT1, EXT2, EXT3: mirror of ENT1–ENT3 with A and B swapped; completion gives exit_pulse.
  - WAIT_CLR: NONE→IDLE; any other code stays in WAIT_CLR.
- Outputs are registered.
  - entry_pulse/exit_pulse assert for exactly the one cycle after the clock edge on which the FSM leaves ENT3/EXT3 on NONE.
  - Entry and exit pulses are mutually exclusive by construction.
  - busy is registered from the next state, so it is aligned with the state register.
- Timeout:
  - The timer clears in IDLE, in WAIT_CLR, and on every state change.
  - In ENT1–3 and EXT1–3 it increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to WAIT_CLR and timeout_pulse asserts for one cycle. No entry or exit pulse is emitted.
  - A beam held blocked indefinitely leaves the FSM in WAIT_CLR with busy=1 and no further pulses.
- Sensors held high through reset release are debounced in normally. The resulting onset follows the IDLE rules: A only → ENT1, B only → EXT1, both → WAIT_CLR.
- Timer width: $clog2(TIMEOUT_CYCLES). Debounce counter width: $clog2(DEBOUNCE_CYCLES+1). All arithmetic is unsigned and never wraps; counters saturate at their terminal value.

Decomposition:
- Package visitor_pkg holds:
  - the FSM state enum (IDLE, ENT1, ENT2, ENT3, EXT1, EXT2, EXT3, WAIT_CLR);
  - the sensor-code constants NONE, A, B, AB.
- Sub-module sensor_debounce (ports clk, reset, raw_in, level_out; parameter DEBOUNCE_CYCLES) contains the 2-flop synchroniser plus the stable counter. It is instantiated twice.
- The FSM, timer and output registers live in the top module.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50):
1. Clean entry: a=1; +20 cycles b=1; +20 a=0; +20 b=0 → exactly one entry_pulse, 6 cycles (2+4) after the raw b fall; exit_pulse stays 0; busy returns to 0 in the same cycle as the pulse.
2. Clean exit: mirror sequence (b, ab, a, none) → exactly one exit_pulse; three back-to-back exits → three pulses and no entry pulses.
3. Bounce: a toggles with 1–3-cycle high glitches for 30 cycles, then a stays at 0 → filtered a never rises, busy stays 0, no pulses.
4. Backout and backtrack:
   - a=1 then a=0 → busy returns to 0 with no pulse.
   - A→AB→A→AB→B→NONE → exactly one entry_pulse.
5. Timeout: a=1 held 100 cycles → timeout_pulse once, about 50 cycles after filtered a rises; busy stays 1 until a=0; then returns to IDLE with no entry pulse.
6. Reset and ambiguity:
   - reset asserted while in ENT2 → next cycle state is IDLE and all outputs are 0; no pulse follows on release of the sensors.
   - a and b rising on the same cycle → WAIT_CLR, then IDLE after both clear, no pulse.
